servo_motion_ctrl: RTL and testbench



---
 rtl/servo_motion_ctrl.sv | 164 ++++++++++++++++
 tb/tb_servo_motion_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_ctrl.sv
// servo_motion_ctrl
//   Sequencing and arbitration front-end for the hobby-servo PWM generator.
//   Two requesters (A, B) submit target angle codes. A round-robin arbiter
//   grants one at a time. The 2-bit angle code then walks toward the target
//   one step per PWM frame boundary, with a dwell of DWELL_FRAMES frames
//   after every step.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   req_a/req_b   level requests, held by the requester until its grant
//   angle_a/_b    target angle codes, sampled when the grant is issued
//   gnt_a/gnt_b   one-cycle grant pulses
//   abort         synchronous abort of the move in progress
//   angle_select  registered angle code to the PWM generator
//   frame_tick    one-cycle pulse on the last cycle of each PWM frame
//   busy          high while a command is in progress
//   done          one-cycle pulse when the target has been reached
module servo_motion_ctrl #(
   parameter int unsigned FRAME_CYCLES = 500001,
   parameter int unsigned DWELL_FRAMES = 25,
   parameter logic [1:0]  HOME_ANGLE   = 2'b00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_a,
   input  logic [1:0] angle_a,
   output logic       gnt_a,
   input  logic       req_b,
   input  logic [1:0] angle_b,
   output logic       gnt_b,
   input  logic       abort,
   output logic [1:0] angle_select,
   output logic       frame_tick,
   output logic       busy,
   output logic       done
);

   localparam int unsigned FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int unsigned DW = $clog2(DWELL_FRAMES + 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
   localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_FRAMES);

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DWELL
   } state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] frame_cnt, frame_cnt_nxt;
   logic [DW-1:0] dwell_cnt, dwell_nxt;
   logic [1:0]    target, target_nxt;
   logic [1:0]    angle_nxt;
   logic          last_grant_b, last_grant_b_nxt;
   logic          gnt_a_nxt, gnt_b_nxt, done_nxt, busy_nxt;

   // Free-running frame timer. frame_tick is registered from the next count
   // so that it is high exactly while the counter holds FRAME_CYCLES-1.
   always_comb begin
      frame_cnt_nxt = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_cnt  <= frame_cnt_nxt;
         frame_tick <= (frame_cnt_nxt == FRAME_LAST);
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt        = state;
      angle_nxt        = angle_select;
      target_nxt       = target;
      dwell_nxt        = dwell_cnt;
      last_grant_b_nxt = last_grant_b;
      gnt_a_nxt        = 1'b0;
      gnt_b_nxt        = 1'b0;
      done_nxt         = 1'b0;

      case (state)
         IDLE: begin
            // Round-robin: on contention the requester not granted last wins.
            if (req_a && (!req_b || last_grant_b)) begin
               gnt_a_nxt        = 1'b1;
               target_nxt       = angle_a;
               last_grant_b_nxt = 1'b0;
               state_nxt        = MOVE;
            end else if (req_b) begin
               gnt_b_nxt        = 1'b1;
               target_nxt       = angle_b;
               last_grant_b_nxt = 1'b1;
               state_nxt        = MOVE;
            end
         end

         MOVE: begin
            if (abort) begin
               dwell_nxt = '0;
               state_nxt = IDLE;
            end else if (frame_tick) begin
               if (angle_select == target) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  // Direction always points at the target, so no wrap.
                  angle_nxt = (target > angle_select) ? angle_select + 2'd1
                                                      : angle_select - 2'd1;
                  dwell_nxt = DWELL_LOAD;
                  state_nxt = DWELL;
               end
            end
         end

         DWELL: begin
            if (abort) begin
               dwell_nxt = '0;
               state_nxt = IDLE;
            end else if (frame_tick) begin
               dwell_nxt = dwell_cnt - DW'(1);
               if (dwell_cnt == DW'(1)) begin
                  state_nxt = MOVE;
               end
            end
         end

         default: begin
            dwell_nxt = '0;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         angle_select <= HOME_ANGLE;
         target       <= HOME_ANGLE;
         dwell_cnt    <= '0;
         last_grant_b <= 1'b1;
         gnt_a        <= 1'b0;
         gnt_b        <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         angle_select <= angle_nxt;
         target       <= target_nxt;
         dwell_cnt    <= dwell_nxt;
         last_grant_b <= last_grant_b_nxt;
         gnt_a        <= gnt_a_nxt;
         gnt_b        <= gnt_b_nxt;
         done         <= done_nxt;
         busy         <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// tb_servo_motion_ctrl
//   Directed bench for servo_motion_ctrl with FRAME_CYCLES=10, DWELL_FRAMES=2.
module tb_servo_motion_ctrl;

   localparam int unsigned FC = 10;
   localparam int unsigned DF = 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       req_a   = 1'b0;
   logic       req_b   = 1'b0;
   logic       abort   = 1'b0;
   logic [1:0] angle_a = 2'd0;
   logic [1:0] angle_b = 2'd0;
   logic       gnt_a, gnt_b, frame_tick, busy, done;
   logic [1:0] angle_select;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Angle after each of the ten frame ticks of a 00 -> 11 move.
   logic [1:0] exp_ang [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

   always #5 clk = ~clk;

   servo_motion_ctrl #(
      .FRAME_CYCLES(FC),
      .DWELL_FRAMES(DF),
      .HOME_ANGLE  (2'b00)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_a       (req_a),
      .angle_a     (angle_a),
      .gnt_a       (gnt_a),
      .req_b       (req_b),
      .angle_b     (angle_b),
      .gnt_b       (gnt_b),
      .abort       (abort),
      .angle_select(angle_select),
      .frame_tick  (frame_tick),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      while (frame_tick !== 1'b1 && n < 25) begin
         step();
         n++;
      end
      check({tag, "_tick_seen"}, frame_tick, 1);
   endtask

   task automatic wait_done(input string tag, output int unsigned steps, output logic saw_gb);
      int n = 0;
      logic [1:0] prev;
      steps  = 0;
      saw_gb = 1'b0;
      prev   = angle_select;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
         if (angle_select !== prev) steps++;
         prev = angle_select;
         if (gnt_b === 1'b1) saw_gb = 1'b1;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_at_done"}, busy, 0);
   endtask

   task automatic wait_grant(input string tag, output logic ga, output logic gb);
      int n = 1;
      step();
      while (!(gnt_a === 1'b1 || gnt_b === 1'b1) && n < 40) begin
         step();
         n++;
      end
      check({tag, "_grant_seen"}, gnt_a | gnt_b, 1);
      ga = gnt_a;
      gb = gnt_b;
   endtask

   // Drops rst_n between clock edges, checks the outputs clear at once,
   // then releases reset on a falling edge.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check({tag, "_angle"}, angle_select, 0);
      check({tag, "_busy"},  busy,  0);
      check({tag, "_gnt_a"}, gnt_a, 0);
      check({tag, "_gnt_b"}, gnt_b, 0);
      check({tag, "_done"},  done,  0);
      check({tag, "_tick"},  frame_tick, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned steps;
      logic        saw_gb, ga, gb;
      int          n;
      logic        bad_ang, bad_done;

      // Reset and frame timer
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         step();
         check("rst_tick", frame_tick, (k % 10 == 9));
      end
      check("rst_angle", angle_select, 0);
      check("rst_busy",  busy,  0);
      check("rst_gnt_a", gnt_a, 0);
      check("rst_gnt_b", gnt_b, 0);
      check("rst_done",  done,  0);

      // Single move 00 -> 11 by A
      angle_a = 2'd3;
      req_a   = 1'b1;
      step();
      check("mv_gnt_a", gnt_a, 1);
      check("mv_gnt_b", gnt_b, 0);
      check("mv_busy",  busy,  1);
      req_a = 1'b0;
      step();
      check("mv_gnt_a_pulse", gnt_a, 0);
      for (int t = 0; t < 10; t++) begin
         wait_tick("mv");
         check("mv_pre_angle", angle_select, (t == 0) ? 0 : exp_ang[t-1]);
         step();
         check("mv_angle", angle_select, exp_ang[t]);
         check("mv_done",  done, (t == 9));
         check("mv_busy_run", busy, (t != 9));
      end
      step();
      check("mv_done_pulse", done, 0);

      // Async reset in the middle of a move 11 -> 00
      angle_b = 2'd0;
      req_b   = 1'b1;
      step();
      check("rm_gnt_b", gnt_b, 1);
      req_b = 1'b0;
      wait_tick("rm");
      step();
      check("rm_angle_step", angle_select, 2);
      check("rm_busy", busy, 1);
      async_reset("rm_rst");

      // Contention straight after reset: A first, B after A's done
      angle_a = 2'd2;
      angle_b = 2'd1;
      req_a   = 1'b1;
      req_b   = 1'b1;
      step();
      check("ct_gnt_a", gnt_a, 1);
      check("ct_gnt_b", gnt_b, 0);
      req_a = 1'b0;
      wait_done("ct_a", steps, saw_gb);
      check("ct_a_steps", steps, 2);
      check("ct_a_no_early_gnt_b", saw_gb, 0);
      check("ct_a_angle", angle_select, 2);
      check("ct_gnt_b_at_done", gnt_b, 0);
      step();
      check("ct_gnt_b_after_done", gnt_b, 1);
      check("ct_busy_b", busy, 1);
      req_b = 1'b0;
      wait_done("ct_b", steps, saw_gb);
      check("ct_b_steps", steps, 1);
      check("ct_b_angle", angle_select, 1);

      // Both requesters held high: grants alternate A, B, A
      angle_a = 2'd1;
      angle_b = 2'd1;
      req_a   = 1'b1;
      req_b   = 1'b1;
      wait_grant("alt1", ga, gb);
      check("alt1_a", ga, 1);
      check("alt1_b", gb, 0);
      wait_grant("alt2", ga, gb);
      check("alt2_a", ga, 0);
      check("alt2_b", gb, 1);
      wait_grant("alt3", ga, gb);
      check("alt3_a", ga, 1);
      check("alt3_b", gb, 0);
      req_a = 1'b0;
      req_b = 1'b0;
      wait_done("alt_end", steps, saw_gb);
      check("alt_angle", angle_select, 1);

      // Abort mid-dwell during 00 -> 11
      async_reset("ab_rst");
      angle_a = 2'd3;
      req_a   = 1'b1;
      step();
      check("ab_gnt_a", gnt_a, 1);
      req_a = 1'b0;
      n = 0;
      while (angle_select !== 2'd1 && n < 40) begin
         step();
         n++;
      end
      check("ab_reach_01", angle_select, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_busy", busy, 0);
      check("ab_angle", angle_select, 1);
      check("ab_done", done, 0);
      bad_ang  = 1'b0;
      bad_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (angle_select !== 2'd1) bad_ang = 1'b1;
         if (done !== 1'b0) bad_done = 1'b1;
      end
      check("ab_angle_held", bad_ang, 0);
      check("ab_no_done", bad_done, 0);
      angle_b = 2'd0;
      req_b   = 1'b1;
      step();
      check("ab_new_gnt_b", gnt_b, 1);
      req_b = 1'b0;
      wait_done("ab_new", steps, saw_gb);
      check("ab_new_steps", steps, 1);
      check("ab_new_angle", angle_select, 0);

      // Null move: target equals current angle
      angle_b = 2'd0;
      req_b   = 1'b1;
      step();
      check("nl_gnt_b", gnt_b, 1);
      check("nl_busy", busy, 1);
      req_b = 1'b0;
      wait_tick("nl");
      check("nl_angle_tick", angle_select, 0);
      step();
      check("nl_done", done, 1);
      check("nl_busy_done", busy, 0);
      check("nl_angle", angle_select, 0);
      step();
      check("nl_done_pulse", done, 0);

      // Abort on a MOVE-state tick; abort with a request in IDLE is ignored
      angle_a = 2'd2;
      req_a   = 1'b1;
      abort   = 1'b1;
      step();
      abort = 1'b0;
      check("at_gnt_a", gnt_a, 1);
      check("at_busy", busy, 1);
      req_a = 1'b0;
      wait_tick("at");
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("at_busy_abort", busy, 0);
      check("at_angle", angle_select, 0);
      check("at_done", done, 0);
      wait_tick("at2");
      step();
      check("at_angle_later", angle_select, 0);
      check("at_done_later", done, 0);
      check("at_busy_later", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
